// File: rtl/rom_loader.sv
// ROM download sequencer: buffers host bytes in a 2-entry FIFO and replays them
// as two-phase writes on the ROM init bus, holding the CPU in reset until settled.
module rom_loader #(
  parameter int unsigned HOLD  = 16,
  parameter logic [15:0] LIMIT = 16'hDFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dlBusy,
  input  logic        dlWr,
  input  logic [15:0] dlA,
  input  logic [7:0]  dlD,
  output logic        dlWait,
  output logic        iniBusy,
  output logic        iniWr,
  output logic [15:0] iniA,
  output logic [7:0]  iniD,
  output logic        hold,
  output logic        done,
  output logic        err,
  output logic [7:0]  sum,
  output logic [15:0] count
);

  localparam logic [15:0] HOLD_CNT = 16'(HOLD);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_SETTLE, ST_RUN} state_t;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE} wstate_t;

  state_t      state_q, state_d;
  wstate_t     wst_q, wst_d;
  logic [23:0] fifo_q [2];
  logic [23:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [15:0] settle_q, settle_d;
  logic        ini_busy_q, ini_busy_d, ini_wr_q, ini_wr_d;
  logic [15:0] ini_a_q, ini_a_d;
  logic [7:0]  ini_d_q, ini_d_d;
  logic        hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] count_q, count_d;

  logic        fifo_full_s, fifo_empty_s, in_range_s, push_s, pop_s;
  logic        drain_done_s, start_s, err_set_s;
  logic [23:0] head_s;

  assign fifo_full_s  = (fifo_cnt_q == 2'd2);
  assign fifo_empty_s = (fifo_cnt_q == 2'd0);
  assign head_s       = fifo_q[rd_ptr_q];
  assign in_range_s   = (dlA <= LIMIT);
  assign push_s       = (state_q == ST_LOAD) && dlWr && !fifo_full_s && in_range_s;
  // The writer may take a new byte whenever it is not mid-byte (idle or finishing a strobe).
  assign pop_s        = !fifo_empty_s && (wst_q != W_SETUP);
  assign drain_done_s = fifo_empty_s && (wst_q != W_SETUP);

  // FIFO storage, pointers and occupancy.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = push_s ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop_s ? ~rd_ptr_q : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = {dlA, dlD};
    end else begin
      fifo_d = fifo_q;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Two-phase writer: SETUP latches the head byte, STROBE pulses iniWr.
  always_comb begin
    wst_d   = wst_q;
    ini_a_d = ini_a_q;
    ini_d_d = ini_d_q;
    case (wst_q)
      W_IDLE:   wst_d = pop_s ? W_SETUP : W_IDLE;
      W_SETUP:  wst_d = W_STROBE;
      W_STROBE: wst_d = pop_s ? W_SETUP : W_IDLE;
      default:  wst_d = W_IDLE;
    endcase
    if (pop_s) begin
      ini_a_d = head_s[23:8];
      ini_d_d = head_s[7:0];
    end else begin
      ini_a_d = ini_a_q;
      ini_d_d = ini_d_q;
    end
    ini_wr_d = (wst_d == W_STROBE);
  end

  // Session FSM, settle timer and byte statistics.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    start_s   = 1'b0;
    err_set_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (dlBusy) begin
          state_d = ST_LOAD;
          start_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        err_set_s = dlWr && (fifo_full_s || !in_range_s);
        state_d   = dlBusy ? ST_LOAD : ST_DRAIN;
      end
      ST_DRAIN: begin
        err_set_s = dlWr;
        if (dlBusy) begin
          state_d = ST_LOAD;
        end else if (drain_done_s) begin
          state_d  = ST_SETTLE;
          settle_d = HOLD_CNT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SETTLE: begin
        if (dlBusy) begin
          state_d = ST_LOAD;
        end else begin
          settle_d = settle_q - 16'd1;
          state_d  = (settle_q <= 16'd1) ? ST_RUN : ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_s) begin
      count_d = 16'd0;
      sum_d   = 8'd0;
      err_d   = 1'b0;
    end else begin
      count_d = (push_s && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
      sum_d   = push_s ? sum_q + dlD : sum_q;
      err_d   = err_q | err_set_s;
    end

    ini_busy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    hold_d     = ini_busy_d || (state_d == ST_SETTLE);
    done_d     = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wst_q      <= W_IDLE;
      fifo_q[0]  <= 24'd0;
      fifo_q[1]  <= 24'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      settle_q   <= 16'd0;
      ini_busy_q <= 1'b0;
      ini_wr_q   <= 1'b0;
      ini_a_q    <= 16'd0;
      ini_d_q    <= 8'd0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sum_q      <= 8'd0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      wst_q      <= wst_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      settle_q   <= settle_d;
      ini_busy_q <= ini_busy_d;
      ini_wr_q   <= ini_wr_d;
      ini_a_q    <= ini_a_d;
      ini_d_q    <= ini_d_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
    end
  end

  assign dlWait  = fifo_full_s;
  assign iniBusy = ini_busy_q;
  assign iniWr   = ini_wr_q;
  assign iniA    = ini_a_q;
  assign iniD    = ini_d_q;
  assign hold    = hold_q;
  assign done    = done_q;
  assign err     = err_q;
  assign sum     = sum_q;
  assign count   = count_q;

endmodule

// File: doc/rom_loader.md
# rom_loader

Download sequencer that owns the ROM initialisation port of the memory block. It accepts a byte stream from the host downloader and buffers it in a 2-entry FIFO. It replays each byte as a two-phase write on the `iniBusy`/`iniWr`/`iniA`/`iniD` bus, which loads the +2 (0x0000–0x7FFF), 48K (0x8000–0xBFFF) and esxDOS (0xC000–0xDFFF) ROM images. It holds the CPU in reset during the load and for a fixed settle time afterwards, and reports the byte count, an 8-bit checksum and an error flag.

## Interface
Parameters:
- `HOLD`, 16: cycles `hold` stays high after the last write completes (1..65535).
- `LIMIT`, 16'hDFFF: highest accepted download address.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dlBusy`  in  1  download session active (level).
- `dlWr`  in  1  byte strobe; one cycle per byte.
- `dlA`  in  16  byte address.
- `dlD`  in  8  byte data.
- `dlWait`  out  1  back-pressure: FIFO full; combinational from FIFO occupancy.
- `iniBusy`  out  1  to memory; ROM address muxes select `iniA`.
- `iniWr`  out  1  to memory; write strobe, one cycle per byte.
- `iniA`  out  16  to memory; write address.
- `iniD`  out  8  to memory; write data.
- `hold`  out  1  CPU/memory reset request, active-high.
- `done`  out  1  last session finished and settle time elapsed.
- `err`  out  1  sticky per session: overflow or out-of-range byte seen.
- `sum`  out  8  mod-256 sum of accepted bytes.
- `count`  out  16  number of accepted bytes.

## Operation
- States: IDLE, LOAD, DRAIN, SETTLE, RUN.
- **Reset** forces IDLE. All outputs are 0 (`iniBusy`, `iniWr`, `iniA`, `iniD`, `hold`, `done`, `err`, `sum`, `count`, `dlWait`). The FIFO is emptied, the writer goes idle and the settle counter is cleared.
- **IDLE → LOAD** and **RUN → LOAD** on the first cycle with `dlBusy`=1.
  - On entry: `count`, `sum`, `err` and `done` clear.
  - `iniBusy`=1 and `hold`=1 from the next cycle.
- **Byte acceptance** (LOAD only). Condition: `dlWr`=1, FIFO not full, `dlA` ≤ `LIMIT`. Effects:
  - push {`dlA`, `dlD`} into the FIFO;
  - `count` +1, saturating at 16'hFFFF;
  - `sum` += `dlD`, wrapping mod 256.
- **Rejections**:
  - `dlWr` while full: byte dropped, `err`=1.
  - `dlA` > `LIMIT`: byte dropped, `err`=1, not counted and not summed.
  - `dlWr` in IDLE, SETTLE or RUN: ignored, no error.
  - `dlWr` in DRAIN: error (the session has ended).
- **Writer**: two-phase, 2 cycles per byte.
  - SETUP: pop the FIFO head into `iniA`/`iniD`, `iniWr`=0.
  - STROBE: `iniWr`=1 with `iniA`/`iniD` unchanged.
  - It returns to SETUP on the next cycle if the FIFO is non-empty, otherwise it goes idle.
  - `iniA`/`iniD` hold their last value when idle.
- **LOAD → DRAIN** when `dlBusy`=0. A `dlWr` in that same cycle is still accepted.
- **DRAIN → SETTLE** when the FIFO is empty and the writer is idle.
  - `iniBusy` drops on entry.
  - The settle counter loads `HOLD`.
- **SETTLE**: `hold`=1; the counter decrements each cycle. At 0 → RUN.
- **RUN**: `hold`=0, `done`=1. `count`, `sum` and `err` stay frozen until the next session.
- **`dlBusy` reasserted in DRAIN or SETTLE**: return to LOAD without clearing `count`/`sum`/`err` (same session). The FIFO contents and any write in flight are preserved.
- **Reset mid-write**: `iniWr` and `iniBusy` are 0 on the cycle after reset is sampled, and the in-flight byte is lost.

## Timing
- Byte sampled at edge E0 → `iniA`/`iniD` valid after E1 → `iniWr`=1 during the cycle after E2.
- Sustained throughput is 1 byte / 2 cycles. With a 2-entry FIFO, a downloader strobing every cycle sees `dlWait` rise and must stall.
- `dlWait` reflects FIFO occupancy in the same cycle, with no push/pop look-ahead. A pop and a push in the same cycle on a full FIFO is still a rejection.
- `iniBusy` is high from the cycle after LOAD entry through the last STROBE cycle inclusive. It falls on the cycle after the last STROBE.
- `hold` stays high `HOLD` cycles after `iniBusy` falls. `done` rises in the same cycle `hold` falls.
- `iniWr` is never 1 while `iniBusy`=0.

## Test plan
- **Reset**: hold `reset`=1 for 3 cycles with random inputs → all outputs 0 and state IDLE.
- **Single byte**: `dlBusy`=1; `dlWr` at 0x8000 with data 0xF3; then drop `dlBusy`.
  - `iniA`=0x8000, `iniD`=0xF3, and `iniWr` pulses once, 2 cycles after `dlWr`.
  - `count`=1, `sum`=0xF3.
  - `hold` falls exactly 16 cycles after `iniBusy` falls; `done`=1.
- **Back-to-back**: `dlWr` on every cycle, addresses 0x0000–0x0009, data = address low byte, stalling on `dlWait`.
  - 10 `iniWr` pulses at 2-cycle spacing, in order.
  - `count`=10, `sum`=0x2D, `err`=0.
- **Range and overflow**:
  - byte at 0xE000 → dropped, `err`=1, `count` unchanged;
  - `dlWr` with `dlWait`=1 → dropped, `err`=1, no `iniWr` for it.
- **Session edge**: `dlWr` in the same cycle `dlBusy` falls → byte written; `count` includes it.
  - `dlBusy` reasserted during SETTLE → `hold` stays 1.
  - `count` continues from its previous value.
- **Reset mid-load**: reset during a STROBE cycle → next cycle `iniBusy`=0, `iniWr`=0, `hold`=0; the FIFO is empty afterwards.
